// File: rtl/matrix_row_collector.sv
// Captures four ALU result rows, then writes the 4x4 matrix row-major to memory.
// Optional COLLECT_COUNT_EN adds a wrapping 8-bit completed-matrix counter.
module matrix_row_collector #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) (
  input  logic              Clock,
  input  logic              ClearAll,
  input  logic              Start,
  input  logic [ADDR_W-1:0] DestAddr,
  input  logic              RowDone,
  input  logic              RowError,
  input  logic [DATA_W-1:0] RowIn1,
  input  logic [DATA_W-1:0] RowIn2,
  input  logic [DATA_W-1:0] RowIn3,
  input  logic [DATA_W-1:0] RowIn4,
  input  logic              MemReady,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemData,
  output logic              Busy,
  output logic              Done,
`ifdef COLLECT_COUNT_EN
  output logic [7:0]        MatrixCount,
`endif
  output logic              Error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] buffer [16];
  logic [ADDR_W-1:0] base;
  logic [1:0]        ridx;
  logic [3:0]        widx;
  logic [3:0]        next_widx;
  logic              prev;
  logic              row_edge;
  logic              capture;

  assign row_edge  = RowDone & ~prev;
  assign capture   = (state == S_COLLECT) & row_edge;
  assign next_widx = widx + 4'd1;

  // Buffer contents are don't-care after reset, so no reset term.
  always_ff @(posedge Clock) begin
    if (capture) begin
      buffer[{ridx, 2'd0}] <= RowIn1;
      buffer[{ridx, 2'd1}] <= RowIn2;
      buffer[{ridx, 2'd2}] <= RowIn3;
      buffer[{ridx, 2'd3}] <= RowIn4;
    end
  end

  always_ff @(posedge Clock or negedge ClearAll) begin
    if (!ClearAll) begin
      state    <= S_IDLE;
      base     <= '0;
      ridx     <= '0;
      widx     <= '0;
      prev     <= 1'b0;
      MemWrite <= 1'b0;
      MemAddr  <= '0;
      MemData  <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Error    <= 1'b0;
    end else begin
      prev <= RowDone;
      Done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (Start) begin
            base  <= DestAddr;
            Error <= 1'b0;
            ridx  <= '0;
            Busy  <= 1'b1;
            state <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (row_edge) begin
            if (RowError) Error <= 1'b1;
            ridx <= ridx + 2'd1;
            // Word 0 lives in row 0, already stored by now.
            if (ridx == 2'd3) begin
              state    <= S_WRITE;
              widx     <= '0;
              MemWrite <= 1'b1;
              MemAddr  <= base;
              MemData  <= buffer[0];
            end
          end
        end
        S_WRITE: begin
          if (row_edge) Error <= 1'b1;
          if (MemReady) begin
            if (widx == 4'd15) begin
              state    <= S_DONE;
              MemWrite <= 1'b0;
              Busy     <= 1'b0;
              Done     <= 1'b1;
            end else begin
              widx    <= next_widx;
              MemAddr <= base + ADDR_W'(next_widx);
              MemData <= buffer[next_widx];
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef COLLECT_COUNT_EN
  always_ff @(posedge Clock or negedge ClearAll) begin
    if (!ClearAll) begin
      MatrixCount <= '0;
    end else if (state == S_DONE) begin
      MatrixCount <= MatrixCount + 8'd1;
    end
  end
`endif

endmodule
